// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mip, trap entry and mret.
// Define CSR_COUNTERS_EN to implement the 64-bit mcycle/minstret counters.
module csr_file #(
   parameter logic [31:0] MTVEC_BASE = 32'h0001_0000,
   parameter int          PC_W       = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [11:0]     i_csr_raddr,
   output logic [31:0]     o_csr_rdata,
   input  logic [1:0]      i_csr_op,
   input  logic [11:0]     i_csr_waddr,
   input  logic [31:0]     i_csr_wdata,
   input  logic            i_ext_irq,
   input  logic            i_trap_take,
   input  logic [PC_W-1:0] i_trap_pc,
   input  logic            i_mret,
   input  logic            i_retire,
   output logic            o_irq_req,
   output logic [31:0]     o_mtvec,
   output logic [PC_W-1:0] o_mepc
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MIP     = 12'h344;
   localparam logic [11:0] A_CYC_LO  = 12'hB00;
   localparam logic [11:0] A_CYC_HI  = 12'hB80;
   localparam logic [11:0] A_INS_LO  = 12'hB02;
   localparam logic [11:0] A_INS_HI  = 12'hB82;

   logic              r_mie;
   logic              r_mpie;
   logic              r_meie;
   logic              r_meip;
   logic [PC_W-1:2]   r_mepc;
   logic [31:0]       w_old;
   logic [31:0]       w_new;
   logic              w_wen;
   logic              w_unused;

`ifdef CSR_COUNTERS_EN
   logic [31:0] r_cyc_lo;
   logic [31:0] r_cyc_hi;
   logic [31:0] r_ins_lo;
   logic [31:0] r_ins_hi;
   logic [32:0] w_cyc_inc;
   logic [32:0] w_ins_inc;
`endif

   // MPP is hardwired to machine mode, so it reads as a constant
   function automatic logic [31:0] f_read(input logic [11:0] a);
      case (a)
         A_MSTATUS: f_read = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
         A_MIE:     f_read = {20'b0, r_meie, 11'b0};
         A_MTVEC:   f_read = MTVEC_BASE;
         A_MEPC:    f_read = 32'({r_mepc, 2'b00});
         A_MIP:     f_read = {20'b0, r_meip, 11'b0};
`ifdef CSR_COUNTERS_EN
         A_CYC_LO:  f_read = r_cyc_lo;
         A_CYC_HI:  f_read = r_cyc_hi;
         A_INS_LO:  f_read = r_ins_lo;
         A_INS_HI:  f_read = r_ins_hi;
`endif
         default:   f_read = 32'h0;
      endcase
   endfunction

   always_comb begin
      o_csr_rdata = f_read(i_csr_raddr);
      w_old       = f_read(i_csr_waddr);
      w_new       = w_old;
      case (i_csr_op)
         2'b01:   w_new = i_csr_wdata;
         2'b10:   w_new = w_old | i_csr_wdata;
         2'b11:   w_new = w_old & ~i_csr_wdata;
         default: w_new = w_old;
      endcase
   end

   assign w_wen     = |i_csr_op;
   assign o_irq_req = r_mie & r_meie & r_meip;
   assign o_mtvec   = MTVEC_BASE;
   assign o_mepc    = {r_mepc, 2'b00};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mie  <= 1'b0;
         r_mpie <= 1'b0;
         r_meie <= 1'b0;
         r_meip <= 1'b0;
         r_mepc <= '0;
      end else begin
         r_meip <= i_ext_irq;
         if (w_wen && i_csr_waddr == A_MIE)
            r_meie <= w_new[11];
         if (i_trap_take) begin
            r_mepc <= i_trap_pc[PC_W-1:2];
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
         end else begin
            if (i_mret) begin
               r_mie  <= r_mpie;
               r_mpie <= 1'b1;
            end else if (w_wen && i_csr_waddr == A_MSTATUS) begin
               r_mie  <= w_new[3];
               r_mpie <= w_new[7];
            end
            if (w_wen && i_csr_waddr == A_MEPC)
               r_mepc <= w_new[PC_W-1:2];
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   assign w_cyc_inc = {1'b0, r_cyc_lo} + 33'd1;
   assign w_ins_inc = {1'b0, r_ins_lo} + {32'd0, i_retire};
   assign w_unused  = ^i_trap_pc[1:0];

   // a written half takes the new value and suppresses its own carry
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cyc_lo <= '0;
         r_cyc_hi <= '0;
         r_ins_lo <= '0;
         r_ins_hi <= '0;
      end else begin
         r_cyc_lo <= (w_wen && i_csr_waddr == A_CYC_LO) ? w_new : w_cyc_inc[31:0];
         if (w_wen && i_csr_waddr == A_CYC_HI)
            r_cyc_hi <= w_new;
         else if (!(w_wen && i_csr_waddr == A_CYC_LO))
            r_cyc_hi <= r_cyc_hi + {31'd0, w_cyc_inc[32]};
         r_ins_lo <= (w_wen && i_csr_waddr == A_INS_LO) ? w_new : w_ins_inc[31:0];
         if (w_wen && i_csr_waddr == A_INS_HI)
            r_ins_hi <= w_new;
         else if (!(w_wen && i_csr_waddr == A_INS_LO))
            r_ins_hi <= r_ins_hi + {31'd0, w_ins_inc[32]};
      end
   end
`else
   assign w_unused = ^{i_retire, i_trap_pc[1:0], w_new[1:0], w_new[6:4], w_new[10:8]};
`endif

endmodule
